// File: rtl/bcd_down_counter_pkg.sv
// bcd_down_counter_pkg: shared BCD constants, mode and run/halt state encodings.
package bcd_down_counter_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_ONESHOT = 1'b1} mode_t;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
endpackage

// File: rtl/bcd_digit_dn.sv
// bcd_digit_dn: one BCD digit register with clamped load and decrement-with-wrap.
module bcd_digit_dn
  import bcd_down_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec,
  output logic [3:0] d,
  output logic       is_zero,
  output logic       clamped
);
  assign clamped = din > BCD_MAX;
  assign is_zero = d == BCD_ZERO;
  always_ff @(posedge clk or posedge rst)
    if (rst) d <= BCD_ZERO;
    else if (load) d <= clamped ? BCD_MAX : din;
    else if (dec) d <= is_zero ? BCD_MAX : d - 4'd1;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: cascadable multi-digit BCD down counter with wrap and one-shot modes.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit ONESHOT_DEFAULT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  input  logic                oneshot,
  output logic [4*DIGITS-1:0] q,
  output logic                zero,
  output logic                borrow,
  output logic                done,
  output logic                halted,
  output logic                load_err
);
  localparam int W = 4 * DIGITS;
  state_t state, state_nxt;
  mode_t mode;
  logic [DIGITS:0] low_zero;
  logic [DIGITS-1:0] is_zero, clamped, dec;
  logic run, borrow_nxt, done_nxt;
  assign low_zero[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    // a digit only borrows once every lower digit sits at zero
    assign low_zero[g+1] = low_zero[g] & is_zero[g];
    assign dec[g] = run & low_zero[g];
    bcd_digit_dn u_dig (
      .clk(clk), .rst(rst), .load(load), .din(load_val[4*g+:4]), .dec(dec[g]),
      .d(q[4*g+:4]), .is_zero(is_zero[g]), .clamped(clamped[g])
    );
  end
  assign zero = low_zero[DIGITS];
  assign halted = state == HALT;
  assign run = en & ~load & ~halted;
  always_comb begin
    borrow_nxt = run & zero & (mode == MODE_WRAP);
    done_nxt = run & (mode == MODE_ONESHOT) & (q == W'(1));
    state_nxt = load ? ((oneshot && load_val == '0) ? HALT : RUN) : (done_nxt ? HALT : state);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ONESHOT_DEFAULT ? HALT : RUN;
      mode <= mode_t'(ONESHOT_DEFAULT);
      borrow <= 1'b0;
      done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_nxt;
      mode <= load ? mode_t'(oneshot) : mode;
      borrow <= borrow_nxt;
      done <= done_nxt;
      load_err <= load & |clamped;
    end
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed checks of load, wrap, one-shot, clamp and async reset.
module tb_bcd_down_counter;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, en = 1'b0, oneshot = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] q;
  logic zero, borrow, done, halted, load_err;
  int checks = 0, errors = 0;
  bcd_down_counter #(.DIGITS(2), .ONESHOT_DEFAULT(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .oneshot(oneshot),
    .q(q), .zero(zero), .borrow(borrow), .done(done), .halted(halted), .load_err(load_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [7:0] wrap_q [13] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
  logic [7:0] os_q [6] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  logic os_done [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic os_halt [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  initial begin
    #12 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_q", q, 8'h00);
      check("rst_zero", zero, 1'b1);
      check("rst_borrow", borrow, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_halted", halted, 1'b0);
    end
    load = 1'b1; load_val = 8'h12; oneshot = 1'b0;
    step();
    check("ld12_q", q, 8'h12);
    check("ld12_err", load_err, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      check("wrap_q", q, wrap_q[i]);
      check("wrap_borrow", borrow, i == 12);
      check("wrap_zero", zero, i == 11);
      check("wrap_halted", halted, 1'b0);
    end
    en = 1'b0;
    step();
    check("hold_q", q, 8'h99);
    check("hold_borrow", borrow, 1'b0);
    load = 1'b1; load_val = 8'h03; oneshot = 1'b1;
    step();
    check("ld03_q", q, 8'h03);
    check("ld03_halted", halted, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("os_q", q, os_q[i]);
      check("os_done", done, os_done[i]);
      check("os_halted", halted, os_halt[i]);
      check("os_borrow", borrow, 1'b0);
    end
    load = 1'b1; load_val = 8'h05;
    step();
    check("ld05_q", q, 8'h05);
    check("ld05_halted", halted, 1'b0);
    check("ld05_done", done, 1'b0);
    load = 1'b0;
    step();
    check("dec04_q", q, 8'h04);
    en = 1'b0; load = 1'b1; load_val = 8'h7C; oneshot = 1'b0;
    step();
    check("clamp7c_q", q, 8'h79);
    check("clamp7c_err", load_err, 1'b1);
    load = 1'b0;
    step();
    check("err_clear", load_err, 1'b0);
    load = 1'b1; load_val = 8'hF3;
    step();
    check("clampf3_q", q, 8'h93);
    check("clampf3_err", load_err, 1'b1);
    load_val = 8'h50; oneshot = 1'b0;
    step();
    check("ld50_q", q, 8'h50);
    load = 1'b0; en = 1'b1;
    step();
    check("dec49_q", q, 8'h49);
    step();
    check("dec48_q", q, 8'h48);
    rst = 1'b1;
    #1;
    check("arst_q", q, 8'h00);
    check("arst_borrow", borrow, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_halted", halted, 1'b0);
    step();
    check("arst_hold_q", q, 8'h00);
    rst = 1'b0;
    step();
    check("post_rst_q", q, 8'h99);
    check("post_rst_borrow", borrow, 1'b1);
    step();
    check("post_rst_q2", q, 8'h98);
    check("post_rst_borrow2", borrow, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Synchronous, cascadable multi-digit BCD (mod-10 per digit) down counter; the decrementing counterpart to the team's mod-10 up counter.
- Used as a countdown timer or event-budget counter: loaded with a BCD value, decremented once per enabled clock.
- Runs in one of two modes:
  - wrap: 0 rolls over to all-nines.
  - one-shot: halts at 0 and reports done.
- No self-generated asynchronous resets. Wrap and halt are decided synchronously, so there are no glitch-driven clears.

Parameters:
DIGITS, 2, number of BCD digits; q width is 4*DIGITS
ONESHOT_DEFAULT, 0, value of the mode register after reset (0 = wrap, 1 = one-shot)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
load  input  1  synchronous load strobe
load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0]
en  input  1  count enable, one decrement per cycle when high
oneshot  input  1  mode select; sampled only when load=1
q  output  4*DIGITS  current BCD count
zero  output  1  q == 0 (combinational from q)
borrow  output  1  registered one-cycle pulse on wrap from 0 to all-nines
done  output  1  registered one-cycle pulse when a one-shot count reaches 0
halted  output  1  one-shot count finished; counting frozen until next load
load_err  output  1  registered one-cycle pulse; load_val contained a digit > 9

Behaviour:
- Reset (async): q=0, borrow=0, done=0, load_err=0, mode=ONESHOT_DEFAULT, halted=ONESHOT_DEFAULT. With halted=1, a one-shot counter does not wrap out of reset.
- Priority per cycle: load > en > hold.
- Load:
  - q <= load_val, with any digit > 9 clamped to 9; load_err=1 next cycle if any digit was clamped.
  - mode <= oneshot; halted <= (oneshot && load_val==0).
  - done and borrow are not asserted on a load cycle.
- Decrement (en=1, load=0, halted=0):
  - Digit 0 always decrements.
  - Digit i>0 decrements only when digits 0..i-1 are all 0 (ripple borrow).
  - A digit at 0 that decrements becomes 9; otherwise it becomes d-1.
  - Latency: q reflects the decrement on the clock edge where en is sampled high.
- Wrap mode (mode=0):
  - q==0 and en → q <= all-nines (e.g. 99 for DIGITS=2).
  - borrow=1 for exactly the next cycle.
  - halted stays 0.
- One-shot mode (mode=1):
  - Transition to 0: the decrement that yields q==0 sets done=1 for the next cycle and halted<=1 on the same edge.
  - While halted=1: en is ignored, q holds at 0, and borrow/done stay 0.
  - Only load clears halted.
- en=0: q holds; borrow and done are 0.
- Simultaneous load and en: the load wins, with no decrement that cycle.
- Reset mid-count: immediate clear per the reset values above; any pending pulses are dropped.
- Every flop is clocked by clk and uses rst asynchronously. zero is the only combinational output.

State machine (per counter):
- RUN: halted=0.
- HALT: halted=1.
- RUN→HALT: on a one-shot decrement to 0.
- HALT→RUN: on load with a nonzero value, or with oneshot=0.
- Any state → RUN/HALT per the load rule when load=1.

Decomposition:
- Shared package: BCD_MAX=4'd9 and BCD_ZERO=4'd0 constants; mode encoding (MODE_WRAP=0, MODE_ONESHOT=1).
- Sub-module bcd_digit_dn holds the per-digit register (async rst), load-with-clamp, and decrement-with-wrap logic.
  - Inputs: clk, rst, load, din, dec.
  - Outputs: d, is_zero, clamped.
- The top instantiates DIGITS copies and chains each dec = en & ~halted & (all lower is_zero). It also holds the mode/halted register and the borrow/done/load_err pulse flops.

Test Plan (DIGITS=2):
- Reset, then hold en=0 for 3 cycles → q=00, zero=1, borrow=0, done=0, halted=ONESHOT_DEFAULT.
- load_val=8'h12, oneshot=0, then en=1 for 13 cycles → q goes 12,11,10,09…00,99; borrow=1 only in the cycle q first reads 99.
- load_val=8'h03, oneshot=1, en=1 for 6 cycles → q goes 03,02,01,00 then holds 00; done=1 for exactly one cycle (the first cycle q=00); halted=1 thereafter; borrow never asserts.
- From halted, load_val=8'h05 with load=1 and en=1 in the same cycle → q=05 with no decrement that cycle, halted=0; the next enabled cycle gives q=04.
- load_val=8'h7C → q=79, load_err=1 for one cycle; load_val=8'hF3 → q=93, load_err=1.
- load_val=8'h50, oneshot=0, en=1; assert rst for 1 cycle after q reaches 48 → q=00 immediately (asynchronously) with no borrow/done pulse; counting resumes from 00 → 99 with a borrow pulse once rst is released.
